// File: rtl/ethstream_len_framer.sv
// Store-and-forward framer: buffers one input frame (or MAX_LEN-byte slice of it)
// and re-emits it as a 2-byte little-endian length prefix followed by the payload.
module ethstream_len_framer #(
    parameter int ADDR_BITS = 11,
    parameter int MAX_LEN   = 1472
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic        s_axis_tlast,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic        split_pulse,
    output logic [15:0] pkt_count
);

    typedef enum logic [1:0] {FILL, HDR_LSB, HDR_MSB, DRAIN} state_t;

    localparam logic [15:0] MAX_LEN_W = 16'(MAX_LEN);

    state_t               state_q, state_d;
    logic [15:0]          len_q, len_d;
    logic [15:0]          pkt_len_q, pkt_len_d;
    logic [15:0]          rd_ptr_q, rd_ptr_d;
    logic [15:0]          pkt_count_q, pkt_count_d;
    logic                 split_q, split_d;
    logic                 s_ready_q;
    logic [7:0]           mem [2**ADDR_BITS];
    logic [7:0]           rd_data_q;
    logic                 in_hs, out_hs, last_byte;
    logic                 wr_en, rd_en;
    logic [ADDR_BITS-1:0] rd_addr;
    logic [15:0]          len_inc;

    // s_ready_q is only ever high while in FILL, so it doubles as the FILL qualifier.
    assign in_hs     = s_axis_tvalid && s_ready_q;
    assign out_hs    = m_axis_tvalid && m_axis_tready;
    assign last_byte = (rd_ptr_q == pkt_len_q - 16'd1);
    assign len_inc   = len_q + 16'd1;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        state_d     = state_q;
        len_d       = len_q;
        pkt_len_d   = pkt_len_q;
        rd_ptr_d    = rd_ptr_q;
        pkt_count_d = pkt_count_q;
        split_d     = 1'b0;
        wr_en       = 1'b0;
        rd_en       = 1'b0;
        rd_addr     = '0;
        case (state_q)
            FILL: begin
                if (in_hs) begin
                    wr_en = 1'b1;
                    len_d = len_inc;
                    if (s_axis_tlast || len_inc == MAX_LEN_W) begin
                        pkt_len_d = len_inc;
                        split_d   = !s_axis_tlast;
                        state_d   = HDR_LSB;
                    end
                end
            end
            HDR_LSB: begin
                if (out_hs) state_d = HDR_MSB;
            end
            HDR_MSB: begin
                // Prefetch mem[0] so the first payload byte is valid on entry to DRAIN.
                rd_en    = 1'b1;
                rd_ptr_d = '0;
                if (out_hs) state_d = DRAIN;
            end
            DRAIN: begin
                if (out_hs) begin
                    if (last_byte) begin
                        pkt_count_d = pkt_count_q + 16'd1;
                        len_d       = '0;
                        state_d     = FILL;
                    end else begin
                        rd_en    = 1'b1;
                        rd_addr  = ADDR_BITS'(rd_ptr_q + 16'd1);
                        rd_ptr_d = rd_ptr_q + 16'd1;
                    end
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: state registers use non-blocking assignments so all update together at the edge.
            state_q     <= FILL;
            len_q       <= '0;
            pkt_len_q   <= '0;
            rd_ptr_q    <= '0;
            pkt_count_q <= '0;
            split_q     <= 1'b0;
            s_ready_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            pkt_len_q   <= pkt_len_d;
            rd_ptr_q    <= rd_ptr_d;
            pkt_count_q <= pkt_count_d;
            split_q     <= split_d;
            s_ready_q   <= (state_d == FILL);
        end
    end

    // NOTE: the buffer and its read register are deliberately not reset; state gates their use.
    always_ff @(posedge clk) begin
        if (wr_en) mem[len_q[ADDR_BITS-1:0]] <= s_axis_tdata;
        if (rd_en) rd_data_q <= mem[rd_addr];
    end

    // Output mux selects only registered values, so it is stable under backpressure.
    always_comb begin
        case (state_q)
            HDR_LSB: m_axis_tdata = pkt_len_q[7:0];
            HDR_MSB: m_axis_tdata = pkt_len_q[15:8];
            DRAIN:   m_axis_tdata = rd_data_q;
            default: m_axis_tdata = 8'h00;
        endcase
    end

    assign m_axis_tvalid = (state_q != FILL);
    assign m_axis_tlast  = (state_q == DRAIN) && last_byte;
    assign s_axis_tready = s_ready_q;
    assign split_pulse   = split_q;
    assign pkt_count     = pkt_count_q;

endmodule

// File: tb/tb_ethstream_len_framer.sv
// Randomized self-checking bench: a frame-level reference model predicts the output
// byte stream, split pulses and packet count for a default and a MAX_LEN=4 instance.
module tb_ethstream_len_framer;

    localparam int LIMIT = 20000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        sel = 1'b0;
    logic [7:0]  s_tdata = 8'h00;
    logic        s_tvalid = 1'b0;
    logic        s_tlast = 1'b0;
    logic        m_tready = 1'b0;

    logic        d0_s_tready, d0_m_tvalid, d0_m_tlast, d0_split;
    logic [7:0]  d0_m_tdata;
    logic [15:0] d0_pkt_count;
    logic        d1_s_tready, d1_m_tvalid, d1_m_tlast, d1_split;
    logic [7:0]  d1_m_tdata;
    logic [15:0] d1_pkt_count;

    logic        obs_s_tready, obs_m_tvalid, obs_m_tlast, obs_split;
    logic [7:0]  obs_m_tdata;
    logic [15:0] obs_pkt_count;

    int          n_checks = 0;
    int          n_pass = 0;
    int          n_fail = 0;
    logic [8:0]  exp_q[$];
    logic [7:0]  in_data[$];
    bit          in_last[$];
    int          exp_cnt[2] = '{0, 0};
    int          exp_splits = 0;

    always #5 clk = ~clk;

    ethstream_len_framer dut0 (
        .clk(clk), .reset_n(reset_n),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid && !sel), .s_axis_tready(d0_s_tready),
        .s_axis_tlast(s_tlast),
        .m_axis_tdata(d0_m_tdata), .m_axis_tvalid(d0_m_tvalid), .m_axis_tready(m_tready),
        .m_axis_tlast(d0_m_tlast), .split_pulse(d0_split), .pkt_count(d0_pkt_count)
    );

    ethstream_len_framer #(.ADDR_BITS(2), .MAX_LEN(4)) dut1 (
        .clk(clk), .reset_n(reset_n),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid && sel), .s_axis_tready(d1_s_tready),
        .s_axis_tlast(s_tlast),
        .m_axis_tdata(d1_m_tdata), .m_axis_tvalid(d1_m_tvalid), .m_axis_tready(m_tready),
        .m_axis_tlast(d1_m_tlast), .split_pulse(d1_split), .pkt_count(d1_pkt_count)
    );

    assign obs_s_tready  = sel ? d1_s_tready  : d0_s_tready;
    assign obs_m_tvalid  = sel ? d1_m_tvalid  : d0_m_tvalid;
    assign obs_m_tlast   = sel ? d1_m_tlast   : d0_m_tlast;
    assign obs_m_tdata   = sel ? d1_m_tdata   : d0_m_tdata;
    assign obs_split     = sel ? d1_split     : d0_split;
    assign obs_pkt_count = sel ? d1_pkt_count : d0_pkt_count;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: slice the frame into packets of at most max_len bytes.
    task automatic add_frame(input int len, input int max_len, input bit rnd, input logic [7:0] base);
        logic [7:0]  pkt[$];
        logic [7:0]  b;
        logic [15:0] sz;
        for (int i = 0; i < len; i++) begin
            b = rnd ? 8'($urandom) : 8'(int'(base) + i);
            in_data.push_back(b);
            in_last.push_back(i == len - 1);
            pkt.push_back(b);
            if (i == len - 1 || pkt.size() == max_len) begin
                sz = 16'(pkt.size());
                exp_q.push_back({1'b0, sz[7:0]});
                exp_q.push_back({1'b0, sz[15:8]});
                for (int k = 0; k < pkt.size(); k++)
                    exp_q.push_back({k == pkt.size() - 1, pkt[k]});
                if (i != len - 1) exp_splits++;
                exp_cnt[sel]++;
                pkt.delete();
            end
        end
    endtask

    task automatic run(input int vprob, input int rprob, input bit timing, input int abort_at);
        int         cyc = 0, out_n = 0, first_out = -1, last_out = -1;
        int         close_cyc = -1, first_valid = -1, splits = 0;
        bit         in_acc = 1'b0, stall = 1'b0, aborted = 1'b0;
        logic [8:0] prev = '0;
        logic [8:0] e;
        while ((in_data.size() > 0 || exp_q.size() > 0) && cyc < LIMIT && !aborted) begin
            @(negedge clk);
            if (in_acc) begin
                void'(in_data.pop_front());
                void'(in_last.pop_front());
                s_tvalid = 1'b0;
            end
            if (!s_tvalid && in_data.size() > 0 && int'($urandom_range(99)) < vprob) begin
                s_tvalid = 1'b1;
                s_tdata  = in_data[0];
                s_tlast  = in_last[0];
            end
            in_acc = s_tvalid && obs_s_tready;
            if (in_acc && s_tlast && close_cyc < 0) close_cyc = cyc;
            m_tready = int'($urandom_range(99)) < rprob;
            if (stall)
                check("stall_hold", 32'({obs_m_tvalid, obs_m_tlast, obs_m_tdata}), 32'({1'b1, prev}));
            if (obs_m_tvalid && first_valid < 0) first_valid = cyc;
            if (obs_split) splits++;
            if (obs_m_tvalid && m_tready) begin
                if (exp_q.size() == 0) check("extra_output", 32'd1, 32'd0);
                else begin
                    e = exp_q.pop_front();
                    check("out_last_data", 32'({obs_m_tlast, obs_m_tdata}), 32'(e));
                end
                out_n++;
                if (first_out < 0) first_out = cyc;
                last_out = cyc;
                if (abort_at > 0 && out_n == abort_at) aborted = 1'b1;
            end
            stall = obs_m_tvalid && !m_tready;
            prev  = {obs_m_tlast, obs_m_tdata};
            cyc++;
        end
        check("within_cycle_budget", 32'(cyc < LIMIT), 32'd1);
        if (aborted) return;
        @(negedge clk);
        if (obs_split) splits++;
        check("split_pulses", 32'(splits), 32'(exp_splits));
        check("pkt_count", 32'(obs_pkt_count), 32'(exp_cnt[sel] % 65536));
        if (timing) begin
            check("turnaround_ready", 32'(obs_s_tready), 32'd1);
            check("latency", 32'(first_valid), 32'(close_cyc + 1));
            check("no_bubbles", 32'(last_out - first_out), 32'(out_n - 1));
        end
        exp_splits = 0;
        m_tready = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_s_tready"}, 32'(obs_s_tready), 32'd0);
        check({tag, "_m_tvalid"}, 32'(obs_m_tvalid), 32'd0);
        check({tag, "_m_tlast"}, 32'(obs_m_tlast), 32'd0);
        check({tag, "_m_tdata"}, 32'(obs_m_tdata), 32'd0);
        check({tag, "_split"}, 32'(obs_split), 32'd0);
        check({tag, "_pkt_count"}, 32'(obs_pkt_count), 32'd0);
    endtask

    initial begin
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        reset_n = 1'b1;
        #1 check("ready_low_at_release", 32'(obs_s_tready), 32'd0);
        @(negedge clk);
        check("ready_after_release", 32'(obs_s_tready), 32'd1);

        // Default instance: single byte, short frame, long frame under backpressure.
        add_frame(1, 1472, 1'b0, 8'hA5);
        run(100, 100, 1'b1, 0);
        add_frame(5, 1472, 1'b0, 8'h11);
        run(100, 100, 1'b1, 0);
        add_frame(300, 1472, 1'b0, 8'h00);
        run(70, 50, 1'b0, 0);
        for (int f = 0; f < 6; f++) add_frame(int'($urandom_range(40, 1)), 1472, 1'b1, 8'h00);
        run(int'($urandom_range(90, 30)), int'($urandom_range(90, 30)), 1'b0, 0);

        // MAX_LEN=4 instance: splits, exact-MAX_LEN frame with tlast, random lengths.
        sel = 1'b1;
        add_frame(10, 4, 1'b0, 8'h00);
        run(100, 100, 1'b0, 0);
        add_frame(4, 4, 1'b1, 8'h00);
        run(100, 100, 1'b1, 0);
        for (int f = 0; f < 8; f++) add_frame(int'($urandom_range(12, 1)), 4, 1'b1, 8'h00);
        run(60, 60, 1'b0, 0);

        // Reset during DRAIN byte 2 of an 8-byte packet, then recover.
        sel = 1'b0;
        add_frame(8, 1472, 1'b1, 8'h00);
        run(100, 100, 1'b0, 4);
        @(negedge clk);
        reset_n = 1'b0;
        #1 check_idle_outputs("mid_drain_reset");
        exp_q.delete();
        in_data.delete();
        in_last.delete();
        exp_cnt = '{0, 0};
        exp_splits = 0;
        s_tvalid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        add_frame(3, 1472, 1'b1, 8'h00);
        run(100, 100, 1'b1, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ethstream_len_framer.md
# ethstream_len_framer

Store-and-forward framer feeding the UDP streamer's transmit input. It accepts arbitrary byte frames on an AXI4-Stream slave, buffers each frame, and counts its bytes. It then re-emits the frame on an AXI4-Stream master as a 2-byte little-endian length prefix followed by the payload, which is the format the streamer consumes. Frames longer than `MAX_LEN` are split into consecutive `MAX_LEN`-byte packets.

## Interface
- `ADDR_BITS`, 11: buffer address width; buffer depth is 2^ADDR_BITS bytes.
- `MAX_LEN`, 1472: maximum payload per emitted packet, in bytes. Legal range is 1..2^ADDR_BITS.

- `clk`  in  1  single clock for all logic.
- `reset_n`  in  1  asynchronous, active-low reset.
- `s_axis_tdata`  in  8  input frame byte.
- `s_axis_tvalid`  in  1  input byte valid.
- `s_axis_tready`  out  1  framer can accept a byte.
- `s_axis_tlast`  in  1  final byte of the input frame.
- `m_axis_tdata`  out  8  length LSB, then length MSB, then payload bytes.
- `m_axis_tvalid`  out  1  output byte valid.
- `m_axis_tready`  in  1  downstream accepts the byte.
- `m_axis_tlast`  out  1  asserted with the final payload byte only.
- `split_pulse`  out  1  one-cycle pulse when a packet is closed by `MAX_LEN` rather than by `tlast`.
- `pkt_count`  out  16  number of packets fully emitted; wraps at 2^16.

## Operation
- Single-frame byte buffer plus a 16-bit count `len`. Four states: FILL, HDR_LSB, HDR_MSB, DRAIN.

- **FILL**
  - `s_axis_tready`=1.
  - Each handshake writes `mem[len]` and increments `len`.
  - The packet closes on a handshake with `tlast`=1, or on the handshake that makes `len`==MAX_LEN. On close, latch `pkt_len` (the new `len`) and go to HDR_LSB.
  - MAX_LEN close without `tlast`: `split_pulse`=1 for one cycle. The remaining bytes of the input frame start the next packet after the current packet drains.
  - MAX_LEN close coinciding with `tlast`: normal close, no `split_pulse`.

- **HDR_LSB**
  - `m_axis_tdata`=`pkt_len[7:0]`, `tvalid`=1, `tlast`=0.
  - Handshake moves to HDR_MSB.

- **HDR_MSB**
  - `m_axis_tdata`=`pkt_len[15:8]`, `tlast`=0.
  - Handshake moves to DRAIN.
  - The read of `mem[0]` is issued during this state so the first payload byte is ready on entry to DRAIN.

- **DRAIN**
  - Emit `mem[0..pkt_len-1]` in order.
  - `m_axis_tlast`=1 on byte `pkt_len-1`.
  - On the last handshake: `pkt_count`++, `len`←0, go to FILL.

- `s_axis_tready`=0 in every state except FILL.
- Output data, valid and last must hold stable while `tvalid`=1 and `tready`=0 (AXI rule). Output is driven from registers or a prefetch/skid stage, never combinationally from `m_axis_tready`.
- Zero-length packets cannot occur: every close includes at least one byte.

## Timing
- **Reset** (asynchronous assert, synchronous-safe release):
  - State → FILL; `len`, `pkt_len`, `pkt_count` → 0.
  - `s_axis_tready`=0, `m_axis_tvalid`=0, `m_axis_tlast`=0, `m_axis_tdata`=0, `split_pulse`=0.
  - `s_axis_tready` rises the first cycle after release.
- **Latency:** close handshake at cycle N → `m_axis_tvalid`=1 with the LSB at N+1.
- **Throughput:** with `m_axis_tready` held high, an L-byte packet occupies the output for exactly L+2 consecutive cycles, with no bubbles between header and payload.
- **Turnaround:** final payload handshake at cycle M → `s_axis_tready`=1 at M+1.
- **Input stalls:** a `tvalid` gap during FILL only delays the close; bytes are never lost or duplicated.
- **Reset mid-DRAIN:** the packet is abandoned, outputs return immediately to reset values, and no partial `tlast` is emitted afterwards.

## Test plan
- **1-byte frame:** input `0xA5` with `tlast` → output `01`,`00`,`A5` (`tlast` on `A5`); `pkt_count`=1.
- **5-byte frame:** input `11..15`, ready held high → output `05`,`00`,`11`..`15` on 7 consecutive cycles; `s_axis_tready` high on the cycle after `15` is accepted.
- **Output backpressure:** 300-byte incrementing frame with `m_axis_tready` randomly toggled → output `2C`,`01`, then bytes `00..FF`,`00..2B` in order, with data stable under stall.
- **Split:** MAX_LEN=4, 10-byte frame `00..09` → packets `04 00 00..03`, `04 00 04..07`, `02 00 08 09`. `split_pulse` fires twice, `tlast` appears three times, `pkt_count`=3.
- **Reset mid-operation:** `reset_n` low during DRAIN byte 2 of an 8-byte packet → all outputs 0 within the reset. The next 3-byte frame emits `03 00 …` correctly and `pkt_count`=1.
- **Count wrap:** 65537 one-byte frames → `pkt_count` reads 1.
